gene_stripe_ctrl: RTL
=====================

# gene_stripe_ctrl

Stripe sequencer directly upstream of `PE_array_64` in the gene-alignment datapath. For each of 16 stripes it fetches the stripe's 64 reference bases (gene 1) from a row-wide memory and presents them on the array's B bus, then streams query bases (gene 2) one per cycle from the running start position. It accumulates the start offset returned by the array, reports per-stripe absolute end position and score, tracks the best stripe, and sequences the final traceback phase.

## Interface
- `N_PE`, 64: PEs per stripe; bases per B row.
- `SEQ_LEN`, 1024: bases per sequence.
- `N_STRIPE`, 16: `SEQ_LEN/N_PE`.
- `SCORE_W`, 14: score width.
- `TIMEOUT`, 2000: stream index limit per stripe.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `i_go` in 1: one-cycle pulse that starts an alignment; honoured only in IDLE.
- `o_b_row` out 4: B-memory row address (stripe index).
- `i_b_row` in 128: B row data, base n in bits [2n+1:2n]; valid 1 cycle after address.
- `o_a_addr` out 10: A-memory address.
- `i_a_data` in 2: A base; valid 1 cycle after address.
- `o_pe_start` out 1: to array `i_start`.
- `o_pe_B` out 128: to array `i_B`.
- `o_pe_A` out 2: to array `i_A`.
- `i_stripe_end` in 1: from array `o_stripe_end`.
- `i_start_position` in 10: from array; offset to add for the next stripe.
- `i_end_position` in 10: from array; relative end position.
- `i_max_score` in 14: from array `o_max_score_stripe`.
- `o_stripe_valid` out 1: one-cycle pulse per completed stripe.
- `o_stripe_idx` out 4: current stripe.
- `o_abs_end` out 11: `i_end_position + start_acc` (zero-extended).
- `o_stripe_score` out 14: captured `i_max_score`.
- `o_best_score` out 14, `o_best_stripe` out 4: running maximum.
- `o_busy` out 1, `o_trace` out 1, `o_done` out 1, `o_error` out 1.

## Operation
- States: IDLE, LOAD_B, SET_B, STREAM, DRAIN, TRACE, DONE.
- IDLE: on `i_go`, clear `start_acc` (11 bit), stripe, best, error → LOAD_B.
- LOAD_B: drive `o_b_row`=stripe → SET_B.
- SET_B: register `i_b_row` into `o_pe_B`, `o_pe_start`=0. Set j=`start_acc` → STREAM if j<1024, else DRAIN.
- STREAM: issue `o_a_addr`=j, j++. Returned data is registered into `o_pe_A` with `o_pe_start`=1. After issuing j=1023 → DRAIN.
- DRAIN: `o_pe_start`=0, `o_pe_A`=0, j keeps counting.
- `i_stripe_end` in STREAM or DRAIN:
  - In-flight reads are discarded; `o_pe_start`=0 the next cycle.
  - Pulse `o_stripe_valid` with `o_abs_end`={0,end}+`start_acc`(old) and `o_stripe_score`.
  - Then `start_acc` += `i_start_position`.
  - Update best only on strict greater, so ties keep the earlier stripe.
  - If stripe==15 → TRACE, else stripe++ → LOAD_B.
- `i_stripe_end` in any other state is ignored.
- Timeout: j reaching `TIMEOUT` in STREAM/DRAIN without `i_stripe_end` → `o_error`=1, DONE.
- TRACE: `o_trace`=1. Ignore the stripe_end pulse that caused entry; the next rising `i_stripe_end` → DONE.
- DONE: `o_done`=1 for one cycle → IDLE. `o_busy`=1 in all states except IDLE.
- `start_acc` is 11 bit and saturates at 2047. A value ≥1024 skips streaming.

## Timing
- All outputs are reset to 0. State is reset to IDLE.
- `i_go` at edge 0 → LOAD_B at edge 1 → `o_pe_B` valid after edge 2 → first `o_pe_start`=1 after edge 4. Address issued at edge n, `o_pe_A` updates at edge n+2.
- `o_stripe_valid` is registered 1 cycle after the `i_stripe_end` sample. The next stripe's LOAD_B follows in the same cycle.
- Reset asserted mid-operation aborts immediately; no pulse outputs are generated.

## Structure
- `gene_pkg`: `N_PE`, `SEQ_LEN`, `N_STRIPE`, `SCORE_W`, base encoding, state enum.
- Single module; best-score tracking is inline. No sub-module required.

## Test plan
- Stub array that returns `start_position`=64, `end_position`=100 every stripe → 16 `o_stripe_valid` pulses. Stripe k reports `o_abs_end`=64k+100, and stripe 15 begins streaming at address 960.
- `i_stripe_end` asserted during stripe 0 after 10 bases → addresses 0..≥9 are seen. `o_pe_start` drops on the next cycle, and no base ≥ address 11 is presented.
- Scores 5,900,900,3 on stripes 0–3 (rest 0) → `o_best_score`=900, `o_best_stripe`=1.
- Cumulative offsets reach 1100 by stripe 3 → stripe 3 goes SET_B→DRAIN, `o_pe_start` stays 0, and `o_abs_end`=1100+end.
- `i_stripe_end` is never asserted → `o_error`=1 when j hits 2000, then `o_done` pulses.
- Reset asserted in STREAM of stripe 7 → all outputs are 0 immediately. A following `i_go` restarts at stripe 0 with `start_acc`=0.

Source files
------------

// File: rtl/gene_pkg.sv
// Shared constants, base encoding and controller state set for the
// gene-alignment stripe sequencer.
package gene_pkg;
   localparam int N_PE     = 64;
   localparam int SEQ_LEN  = 1024;
   localparam int N_STRIPE = SEQ_LEN / N_PE;
   localparam int SCORE_W  = 14;
   localparam int TIMEOUT  = 2000;
   localparam int ACC_W    = 11;

   localparam logic [ACC_W-1:0] SEQ_END     = ACC_W'(SEQ_LEN);
   localparam logic [ACC_W-1:0] LAST_ADDR   = ACC_W'(SEQ_LEN - 1);
   localparam logic [ACC_W-1:0] TIMEOUT_J   = ACC_W'(TIMEOUT);
   localparam logic [3:0]       LAST_STRIPE = 4'(N_STRIPE - 1);

   typedef enum logic [1:0] {BASE_A, BASE_C, BASE_G, BASE_T} base_t;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_B, S_SET_B, S_STREAM, S_DRAIN, S_TRACE, S_DONE
   } state_t;
endpackage

// File: rtl/gene_stripe_ctrl.sv
// Stripe sequencer feeding PE_array_64: loads each stripe's reference row,
// streams query bases from the running offset, and tracks per-stripe results.
module gene_stripe_ctrl
   import gene_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_go,
   output logic [3:0]           o_b_row,
   input  logic [2*N_PE-1:0]    i_b_row,
   output logic [9:0]           o_a_addr,
   input  logic [1:0]           i_a_data,
   output logic                 o_pe_start,
   output logic [2*N_PE-1:0]    o_pe_B,
   output logic [1:0]           o_pe_A,
   input  logic                 i_stripe_end,
   input  logic [9:0]           i_start_position,
   input  logic [9:0]           i_end_position,
   input  logic [SCORE_W-1:0]   i_max_score,
   output logic                 o_stripe_valid,
   output logic [3:0]           o_stripe_idx,
   output logic [ACC_W-1:0]     o_abs_end,
   output logic [SCORE_W-1:0]   o_stripe_score,
   output logic [SCORE_W-1:0]   o_best_score,
   output logic [3:0]           o_best_stripe,
   output logic                 o_busy,
   output logic                 o_trace,
   output logic                 o_done,
   output logic                 o_error
);

   state_t           state;
   logic [3:0]       stripe;
   logic [ACC_W-1:0] start_acc;
   logic [ACC_W-1:0] j;
   logic             vld_p0;
   logic             stripe_end_p0;

   // Offsets past 2047 pin at 2047 so later stripes skip streaming.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                                input logic [9:0] inc);
      logic [ACC_W:0] sum;
      sum = {1'b0, acc} + {2'b00, inc};
      return sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state          <= S_IDLE;
         stripe         <= '0;
         start_acc      <= '0;
         j              <= '0;
         vld_p0         <= 1'b0;
         stripe_end_p0  <= 1'b0;
         o_b_row        <= '0;
         o_a_addr       <= '0;
         o_pe_start     <= 1'b0;
         o_pe_B         <= '0;
         o_pe_A         <= '0;
         o_stripe_valid <= 1'b0;
         o_stripe_idx   <= '0;
         o_abs_end      <= '0;
         o_stripe_score <= '0;
         o_best_score   <= '0;
         o_best_stripe  <= '0;
         o_busy         <= 1'b0;
         o_trace        <= 1'b0;
         o_done         <= 1'b0;
         o_error        <= 1'b0;
      end else begin
         o_stripe_valid <= 1'b0;
         o_done         <= 1'b0;
         stripe_end_p0  <= i_stripe_end;
         // p0 -> output: A data returned for the address issued last cycle
         o_pe_start     <= vld_p0;
         o_pe_A         <= vld_p0 ? i_a_data : 2'b00;
         vld_p0         <= 1'b0;

         case (state)
            S_IDLE: begin
               if (i_go) begin
                  start_acc     <= '0;
                  stripe        <= '0;
                  o_best_score  <= '0;
                  o_best_stripe <= '0;
                  o_error       <= 1'b0;
                  o_b_row       <= '0;
                  o_stripe_idx  <= '0;
                  o_busy        <= 1'b1;
                  state         <= S_LOAD_B;
               end
            end
            S_LOAD_B: begin
               o_stripe_idx <= stripe;
               state        <= S_SET_B;
            end
            S_SET_B: begin
               o_pe_B   <= i_b_row;
               j        <= start_acc;
               o_a_addr <= start_acc[9:0];
               state    <= (start_acc < SEQ_END) ? S_STREAM : S_DRAIN;
            end
            S_STREAM, S_DRAIN: begin
               if (i_stripe_end) begin
                  o_pe_start     <= 1'b0;
                  o_pe_A         <= 2'b00;
                  o_stripe_valid <= 1'b1;
                  o_abs_end      <= {1'b0, i_end_position} + start_acc;
                  o_stripe_score <= i_max_score;
                  start_acc      <= sat_add(start_acc, i_start_position);
                  if (i_max_score > o_best_score) begin
                     o_best_score  <= i_max_score;
                     o_best_stripe <= stripe;
                  end
                  if (stripe == LAST_STRIPE) begin
                     o_trace <= 1'b1;
                     state   <= S_TRACE;
                  end else begin
                     stripe  <= stripe + 4'd1;
                     o_b_row <= stripe + 4'd1;
                     state   <= S_LOAD_B;
                  end
               end else if (j >= TIMEOUT_J) begin
                  o_error <= 1'b1;
                  o_done  <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  j <= j + 11'd1;
                  if (state == S_STREAM) begin
                     vld_p0   <= 1'b1;
                     o_a_addr <= j[9:0] + 10'd1;
                     if (j == LAST_ADDR) state <= S_DRAIN;
                  end
               end
            end
            S_TRACE: begin
               // Only a fresh rising edge ends traceback, never the entry pulse.
               if (i_stripe_end && !stripe_end_p0) begin
                  o_trace <= 1'b0;
                  o_done  <= 1'b1;
                  state   <= S_DONE;
               end
            end
            S_DONE: begin
               o_busy <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
